riscv_fetch_unit: RTL and testbench

RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

---
 rtl/riscv_fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// ----------------------------------------------------------------------------
// riscv_fetch_unit
//
// Instruction fetch front end. Issues sequential word fetches to an
// instruction memory with a valid/grant request channel and an in-order
// response channel, buffers returned words together with their PCs in a
// small FIFO, and presents them to decode with a valid/ready handshake.
// A redirect from execute flushes the buffer, re-targets the fetch PC and
// discards every response still in flight for the old path.
//
// State | meaning
// ------+---------------------------------------------------------------
// RESET_HOLD | first cycle after reset release, no request issued
// RUN        | normal fetching, requests limited by the credit budget
// DRAIN      | redirect pending, waiting for stale responses (drop > 0)
//
// Ports
//   i_riscv_clk       clock, all state on rising edge
//   i_riscv_rst       asynchronous active-low reset
//   o_imem_req        request valid
//   o_imem_addr       request address (current fetch PC)
//   i_imem_gnt        request accepted this cycle
//   i_imem_rvalid     response valid (in request order)
//   i_imem_rdata      response instruction word
//   o_fstage_valid    instruction presented to decode
//   o_fstage_instr    instruction word at FIFO head
//   o_fstage_pc       PC of the presented instruction
//   o_fstage_pcplus4  o_fstage_pc + 4
//   i_dstage_ready    decode accepts (low = stall)
//   i_redirect_valid  redirect request from execute
//   i_redirect_pc     redirect target (word aligned internally)
// ----------------------------------------------------------------------------
module riscv_fetch_unit #(
    parameter logic [63:0] RESET_PC        = 64'h0,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        i_riscv_clk,
    input  logic        i_riscv_rst,
    output logic        o_imem_req,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_fstage_valid,
    output logic [31:0] o_fstage_instr,
    output logic [63:0] o_fstage_pc,
    output logic [63:0] o_fstage_pcplus4,
    input  logic        i_dstage_ready,
    input  logic        i_redirect_valid,
    input  logic [63:0] i_redirect_pc
);

    localparam int            CW       = $clog2(MAX_OUTSTANDING + 1);
    localparam int            PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW:0]   MAX_OCC  = (CW + 1)'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_IDX = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        DRAIN      = 2'd2
    } state_t;

    state_t        state_q;
    logic [63:0]   fetch_pc_q;
    logic [CW-1:0] outst_q;
    logic [CW-1:0] drop_q;
    logic [CW-1:0] fifo_count_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [31:0]   fifo_instr_q [MAX_OUTSTANDING];
    logic [63:0]   fifo_pc_q    [MAX_OUTSTANDING];

    logic          fifo_nonempty;
    logic          pop;
    logic          rsp;
    logic          push;
    logic          drop_rsp;
    logic          credit_ok;
    logic          req_fire;
    logic [CW:0]   occupancy;
    logic [CW-1:0] outst_next;
    logic [CW-1:0] drop_next;
    logic [63:0]   rsp_pc;
    logic [63:0]   head_pc;
    logic          unused_redirect_lsb;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    // Redirect targets are forced to word alignment; the two low bits are
    // intentionally ignored.
    assign unused_redirect_lsb = ^i_redirect_pc[1:0];

    assign fifo_nonempty = (fifo_count_q != '0);

    // A redirect flushes the FIFO, so the head is not consumed that cycle.
    assign pop = fifo_nonempty && i_dstage_ready && !i_redirect_valid;

    // A response with nothing outstanding cannot belong to us; ignore it.
    assign rsp      = i_imem_rvalid && (outst_q != '0);
    assign drop_rsp = rsp && (drop_q != '0);
    assign push     = rsp && (drop_q == '0) && !i_redirect_valid;

    // Credit budget counts in-flight plus buffered entries. The slot freed
    // by this cycle's pop is handed straight back to the request side so a
    // single-cycle memory can stream one instruction per cycle.
    assign occupancy = {1'b0, outst_q} + {1'b0, fifo_count_q} - (CW + 1)'(pop);
    assign credit_ok = (occupancy < MAX_OCC);

    assign o_imem_req  = (state_q == RUN) && !i_redirect_valid && credit_ok;
    assign o_imem_addr = fetch_pc_q;
    assign req_fire    = o_imem_req && i_imem_gnt;

    assign outst_next = outst_q + CW'(req_fire) - CW'(rsp);
    assign drop_next  = drop_q - CW'(drop_rsp);

    // Outside DRAIN all outstanding requests are a contiguous run of words
    // ending just below the fetch PC, so the oldest one sits outst words back.
    assign rsp_pc = fetch_pc_q - (64'(outst_q) << 2);

    always_ff @(posedge i_riscv_clk or negedge i_riscv_rst) begin
        if (!i_riscv_rst) begin
            state_q      <= RESET_HOLD;
            fetch_pc_q   <= RESET_PC;
            outst_q      <= '0;
            drop_q       <= '0;
            fifo_count_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            outst_q <= outst_next;
            if (i_redirect_valid) begin
                fetch_pc_q   <= {i_redirect_pc[63:2], 2'b00};
                drop_q       <= outst_next;
                fifo_count_q <= '0;
                rd_ptr_q     <= '0;
                wr_ptr_q     <= '0;
                state_q      <= (outst_next != '0) ? DRAIN : RUN;
            end else begin
                if (req_fire) begin
                    fetch_pc_q <= fetch_pc_q + 64'd4;
                end
                drop_q <= drop_next;
                if (push) begin
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
                fifo_count_q <= fifo_count_q + CW'(push) - CW'(pop);
                case (state_q)
                    RESET_HOLD: state_q <= RUN;
                    RUN:        state_q <= RUN;
                    DRAIN:      if (drop_next == '0) state_q <= RUN;
                    default:    state_q <= RUN;
                endcase
            end
        end
    end

    // Storage needs no reset: every read is qualified by the FIFO count.
    always_ff @(posedge i_riscv_clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= i_imem_rdata;
            fifo_pc_q[wr_ptr_q]    <= rsp_pc;
        end
    end

    assign head_pc = fifo_pc_q[rd_ptr_q];

    assign o_fstage_valid   = fifo_nonempty;
    assign o_fstage_instr   = fifo_nonempty ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign o_fstage_pc      = fifo_nonempty ? head_pc : 64'h0;
    assign o_fstage_pcplus4 = fifo_nonempty ? head_pc + 64'd4 : 64'h0;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_riscv_fetch_unit
//
// Bench for riscv_fetch_unit. A small instruction memory (in-order queue with
// per-request latency) answers the DUT. A reference model built from queues
// of outstanding request PCs (each flagged stale after a redirect) and of
// buffered {instr, pc} entries predicts the request and decode outputs every
// cycle. Directed scenarios add literal expectations, then a long random run.
// ----------------------------------------------------------------------------
module tb_riscv_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          MAXO     = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        fvalid;
    logic [31:0] finstr;
    logic [63:0] fpc;
    logic [63:0] fpc4;
    logic        ready;
    logic        redirect;
    logic [63:0] rpc;

    always #5 clk = ~clk;

    riscv_fetch_unit #(
        .RESET_PC        (RESET_PC),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .i_riscv_clk      (clk),
        .i_riscv_rst      (rst_n),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_gnt       (gnt),
        .i_imem_rvalid    (rvalid),
        .i_imem_rdata     (rdata),
        .o_fstage_valid   (fvalid),
        .o_fstage_instr   (finstr),
        .o_fstage_pc      (fpc),
        .o_fstage_pcplus4 (fpc4),
        .i_dstage_ready   (ready),
        .i_redirect_valid (redirect),
        .i_redirect_pc    (rpc)
    );

    typedef struct {
        logic [63:0] pc;
        bit          stale;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mem_t;

    out_t        m_out[$];
    ent_t        m_fifo[$];
    mem_t        mem_q[$];
    logic [63:0] m_pc;
    bit          m_hold;
    int          cyc;
    int          last_due;
    int          lat_min;
    int          lat_max;
    int          n_cmp;
    int          n_err;

    logic        s_req;
    logic        s_valid;
    logic [63:0] s_addr;
    logic [63:0] s_pc;
    logic [63:0] s_pc4;
    logic [31:0] s_instr;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_out.delete();
        m_fifo.delete();
        mem_q.delete();
        m_pc     = RESET_PC;
        m_hold   = 1'b1;
        last_due = -1;
    endtask

    // One clock cycle: drive memory response, sample at negedge, compare
    // against the model, advance model and memory, then step past posedge.
    task automatic step();
        bit   exp_req;
        bit   exp_valid;
        bit   pop;
        int   stale_n;
        int   occ;
        int   d;
        out_t r;
        if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mem_word(mem_q[0].addr);
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
        end
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = fvalid;
        s_instr = finstr;
        s_pc    = fpc;
        s_pc4   = fpc4;
        if (!rst_n) begin
            chk("rst_imem_req", s_req, 0);
            chk("rst_fstage_valid", s_valid, 0);
            chk("rst_fstage_instr", s_instr, 0);
            chk("rst_fstage_pc", s_pc, 0);
            chk("rst_fstage_pcplus4", s_pc4, 0);
            model_reset();
        end else begin
            exp_valid = (m_fifo.size() > 0);
            pop       = exp_valid && ready && !redirect;
            stale_n   = 0;
            foreach (m_out[i]) if (m_out[i].stale) stale_n++;
            occ     = m_out.size() + m_fifo.size() - (pop ? 1 : 0);
            exp_req = !m_hold && (stale_n == 0) && !redirect && (occ < MAXO);
            chk("imem_req", s_req, exp_req);
            if (exp_req) chk("imem_addr", s_addr, m_pc);
            chk("fstage_valid", s_valid, exp_valid);
            if (exp_valid) begin
                chk("fstage_instr", s_instr, m_fifo[0].instr);
                chk("fstage_pc", s_pc, m_fifo[0].pc);
                chk("fstage_pcplus4", s_pc4, m_fifo[0].pc + 64'd4);
            end
            // memory side
            if (rvalid) void'(mem_q.pop_front());
            if (s_req && gnt) begin
                d = cyc + int'($urandom_range(lat_max, lat_min));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                mem_q.push_back('{s_addr, d});
            end
            // model update
            if (rvalid && m_out.size() > 0) begin
                r = m_out.pop_front();
                if (!r.stale && !redirect) m_fifo.push_back('{rdata, r.pc});
            end
            if (redirect) begin
                m_fifo.delete();
                foreach (m_out[i]) m_out[i].stale = 1'b1;
                m_pc = {rpc[63:2], 2'b00};
            end else begin
                if (pop) void'(m_fifo.pop_front());
                if (exp_req && gnt) begin
                    m_out.push_back('{m_pc, 1'b0});
                    m_pc = m_pc + 64'd4;
                end
            end
            m_hold = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Leaves reset released just after a posedge; the next step() samples
    // the RESET_HOLD cycle.
    task automatic do_reset();
        rst_n    = 1'b0;
        gnt      = 1'b0;
        ready    = 1'b0;
        redirect = 1'b0;
        rpc      = '0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [63:0] wrap_addr [3];
    int          nw;

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        gnt      = 1'b0;
        ready    = 1'b0;
        redirect = 1'b0;
        rpc      = '0;
        rvalid   = 1'b0;
        rdata    = '0;
        lat_min  = 1;
        lat_max  = 1;
        model_reset();
        #1;

        // Streaming from reset with a single-cycle memory
        do_reset();
        gnt = 1'b1; ready = 1'b1; lat_min = 1; lat_max = 1;
        for (int k = 0; k < 7; k++) begin
            step();
            case (k)
                0: chk("A_req_hold", s_req, 0);
                1: begin chk("A_req1", s_req, 1); chk("A_addr1", s_addr, 64'h0); end
                2: begin chk("A_addr2", s_addr, 64'h4); chk("A_valid2", s_valid, 0); end
                3: begin
                    chk("A_addr3", s_addr, 64'h8);
                    chk("A_valid3", s_valid, 1);
                    chk("A_pc3", s_pc, 64'h0);
                    chk("A_pc4_3", s_pc4, 64'h4);
                end
                4: chk("A_pc4", s_pc, 64'h4);
                5: chk("A_pc5", s_pc, 64'h8);
                default: ;
            endcase
        end

        // Decode stalled: credits run out, head held
        do_reset();
        gnt = 1'b1; ready = 1'b0;
        for (int k = 0; k < 11; k++) begin
            if (k == 8) ready = 1'b1;
            step();
            if (k >= 3 && k <= 7) begin
                chk("B_req_stalled", s_req, 0);
                chk("B_head_pc", s_pc, 64'h0);
            end
            if (k == 9)  chk("B_resume_pc", s_pc, 64'h4);
            if (k == 10) chk("B_next_pc", s_pc, 64'h8);
        end

        // Redirect with two requests in flight (3-cycle memory)
        do_reset();
        gnt = 1'b1; ready = 1'b1; lat_min = 3; lat_max = 3;
        step(); step(); step();
        redirect = 1'b1; rpc = 64'h0010_0010;
        step();
        chk("C_req_redirect", s_req, 0);
        redirect = 1'b0;
        step();
        chk("C_req_drain1", s_req, 0);
        chk("C_valid_drain1", s_valid, 0);
        step();
        chk("C_req_drain2", s_req, 0);
        step();
        chk("C_req_after", s_req, 1);
        chk("C_addr_after", s_addr, 64'h0010_0010);
        for (int k = 0; k < 10 && !s_valid; k++) step();
        chk("C_first_valid", s_valid, 1);
        chk("C_first_pc", s_pc, 64'h0010_0010);

        // Redirect coincident with a response, unaligned target
        do_reset();
        gnt = 1'b1; ready = 1'b1; lat_min = 1; lat_max = 1;
        step(); step();
        redirect = 1'b1; rpc = 64'h103;
        step();
        chk("D_req_redirect", s_req, 0);
        redirect = 1'b0;
        step();
        chk("D_addr", s_addr, 64'h100);
        chk("D_req", s_req, 1);
        chk("D_dropped", s_valid, 0);
        step();
        step();
        chk("D_pc", s_pc, 64'h100);

        // Grant held low, then PC wrap
        do_reset();
        gnt = 1'b1; ready = 1'b1;
        step(); step(); step();
        gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("E_req_held", s_req, 1);
            chk("E_addr_held", s_addr, 64'h8);
        end
        gnt = 1'b1;
        step();
        chk("E_addr_grant", s_addr, 64'h8);
        step();
        chk("E_addr_next", s_addr, 64'hC);
        redirect = 1'b1; rpc = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        redirect = 1'b0;
        nw = 0;
        for (int i = 0; i < 3; i++) wrap_addr[i] = 64'h1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (s_req && gnt && nw < 3) begin
                wrap_addr[nw] = s_addr;
                nw++;
            end
        end
        chk("E_wrap0", wrap_addr[0], 64'hFFFF_FFFF_FFFF_FFF8);
        chk("E_wrap1", wrap_addr[1], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("E_wrap2", wrap_addr[2], 64'h0);

        // Asynchronous reset with a full FIFO
        do_reset();
        gnt = 1'b1; ready = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("F_full_valid", s_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("F_async_req", imem_req, 0);
        chk("F_async_valid", fvalid, 0);
        chk("F_async_instr", finstr, 0);
        chk("F_async_pc", fpc, 0);
        chk("F_async_pcplus4", fpc4, 0);
        model_reset();
        @(posedge clk);
        #1;
        step();
        step();
        rst_n = 1'b1;
        gnt = 1'b1; ready = 1'b1;
        step();
        chk("F_hold_req", s_req, 0);
        step();
        chk("F_first_req", s_req, 1);
        chk("F_first_addr", s_addr, RESET_PC);

        // Random traffic
        do_reset();
        lat_min = 1; lat_max = 3;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(599, 0) == 0) begin
                do_reset();
            end
            gnt      = ($urandom_range(9, 0) < 7);
            ready    = ($urandom_range(9, 0) < 7);
            redirect = ($urandom_range(99, 0) < 4);
            case ($urandom_range(3, 0))
                0: rpc = {$urandom, $urandom};
                1: rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15, 0));
                2: rpc = 64'($urandom_range(255, 0));
                default: rpc = 64'h8000_0000 + 64'($urandom_range(4095, 0));
            endcase
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
